// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package loader_pkg;

  localparam int CNT_W          = 16;
  localparam int CSUM_W         = 8;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    ST_HDR_LO,
    ST_HDR_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } loader_state_e;

  function automatic logic is_loading(input loader_state_e s);
    return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles little-endian bytes into 32-bit words; pulses word_valid the
// cycle after the fourth byte of a word is taken.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane_reg;
  logic [31:0] word_reg;
  logic        valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_reg  <= 2'd0;
      word_reg  <= 32'd0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (clr) begin
        lane_reg <= 2'd0;
      end else if (byte_en) begin
        // First byte ends up in bits [7:0] after four shifts.
        word_reg  <= {byte_in, word_reg[31:8]};
        lane_reg  <= lane_reg + 2'd1;
        valid_reg <= (lane_reg == LAST_LANE);
      end
    end
  end

  assign word_valid = valid_reg;
  assign word       = word_reg;

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: parses a framed byte stream into instruction memory and
// holds the core in reset until a checksum-valid image has been written.
module imem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  loader_state_e     state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [1:0]        byte_cnt_reg;
  logic [ADDR_W-1:0] word_cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [CSUM_W-1:0] sum_reg;
  logic              done_reg;
  logic              ready_en_reg;

  logic              accept;
  logic [CNT_W-1:0]  hdr_cnt;
  logic              hdr_ok;
  logic              word_last_byte;
  logic              last_word;
  logic              pack_valid;
  logic [31:0]       pack_word;

  assign accept         = rx_valid && rx_ready;
  assign hdr_cnt        = {rx_data, cnt_reg[7:0]};
  assign hdr_ok         = (hdr_cnt != '0) && (hdr_cnt <= CNT_W'(DEPTH));
  assign word_last_byte = (byte_cnt_reg == LAST_LANE);
  assign last_word      = (CNT_W'(word_cnt_reg) == cnt_reg - CNT_W'(1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_HDR_LO: if (accept) state_next = ST_HDR_HI;
      ST_HDR_HI: if (accept) state_next = hdr_ok ? ST_DATA : ST_ERR;
      ST_DATA:   if (accept && word_last_byte && last_word) state_next = ST_CSUM;
      ST_CSUM:   if (accept) state_next = (rx_data == sum_reg) ? ST_DONE : ST_ERR;
      default:   state_next = state_reg;
    endcase
    if (start) state_next = ST_HDR_LO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_HDR_LO;
      cnt_reg      <= '0;
      byte_cnt_reg <= 2'd0;
      word_cnt_reg <= '0;
      addr_reg     <= '0;
      sum_reg      <= '0;
      done_reg     <= 1'b0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ready_en_reg <= 1'b1;
      // Release lags the checksum edge by one cycle so the last write lands first.
      done_reg     <= (state_reg == ST_DONE) && !start;
      if (start) begin
        byte_cnt_reg <= 2'd0;
        word_cnt_reg <= '0;
        sum_reg      <= '0;
      end else if (accept) begin
        case (state_reg)
          ST_HDR_LO: cnt_reg[7:0]       <= rx_data;
          ST_HDR_HI: cnt_reg[CNT_W-1:8] <= rx_data;
          ST_DATA: begin
            sum_reg      <= sum_reg + rx_data;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            if (word_last_byte) begin
              addr_reg     <= word_cnt_reg;
              word_cnt_reg <= word_cnt_reg + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start),
    .byte_en    (accept && !start && (state_reg == ST_DATA)),
    .byte_in    (rx_data),
    .word_valid (pack_valid),
    .word       (pack_word)
  );

  assign rx_ready   = ready_en_reg && is_loading(state_reg);
  assign busy       = is_loading(state_reg);
  assign done       = done_reg;
  assign core_rst_n = done_reg;
  assign error      = (state_reg == ST_ERR);
  assign imem_we    = pack_valid;
  assign imem_addr  = addr_reg;
  assign imem_wdata = pack_word;

endmodule
